ak5394a_rate_sequencer: RTL and testbench
=========================================

// Module: ak5394a_rate_sequencer
// PURPOSE
//  Owns AK5394A reset, rate-select (DFS1:DFS0) and calibration sequencing.
//  Runs on ADC_MCLK (12.288MHz) between host control logic and the ADC pins.
//  Sequence: power-up VREF settle, reset, calibration, then RUN.
//  Accepts rate-change requests and re-runs reset+calibration safely; gates capture via adc_run.
// PARAMETERS
//  VREF_DELAY   25'hCE5000  ADC_MCLK cycles RSTN held high after power-up (~1.1s VREF settle)
//  RST_CYCLES   4           ADC_RSTN low width, cycles (>=3 required by ADC)
//  CAL_RISE_WIN 1024        max cycles after RSTN release for ADC_CAL to be seen high
//  CAL_TIMEOUT  24'h100000  max cycles ADC_CAL may stay high before error
// PORTS
//  ADC_MCLK       in   1  clock, all state on rising edge
//  reset          in   1  asynchronous, active-high reset
//  rate_req       in   2  requested mode: 00 normal(48k), 01 double(96k), 10 quad(192k), 11 illegal
//  rate_req_valid in   1  request strobe
//  rate_req_ready out  1  request accepted this cycle when valid&ready
//  req_reject     out  1  one-cycle pulse: valid&ready with rate_req==11
//  ADC_CAL        in   1  AK5394A CAL pin, asynchronous, high while calibrating
//  ADC_RSTN       out  1  AK5394A RSTN pin
//  ADC_DFS        out  2  AK5394A {DFS1,DFS0} pins
//  adc_run        out  1  high only in RUN: capture logic may use ADC data
//  cal_error      out  1  high in ERROR state
//  rate_cur       out  2  mode currently driven on ADC_DFS
// BEHAVIOUR
//  Reset (async): state=PWRUP, counter=0, ADC_RSTN=0, ADC_DFS=00, rate_cur=00,
//   adc_run=0, cal_error=0, rate_req_ready=0, req_reject=0, pending rate=00.
//  All outputs registered. ADC_CAL synchronized by 2 flops; cal_s = synced value.
//  States:
//  PWRUP: ADC_RSTN=1; count to VREF_DELAY-1, then -> RST, counter cleared.
//  RST: ADC_RSTN=0; ADC_DFS<=pending rate on entry cycle; after RST_CYCLES cycles -> CAL_RISE.
//   ADC_DFS only changes while ADC_RSTN=0.
//  CAL_RISE: ADC_RSTN=1; cal_s=1 -> CAL_FALL, counter cleared;
//   CAL_RISE_WIN cycles elapsed without cal_s -> ERROR.
//  CAL_FALL: cal_s=0 -> RUN; CAL_TIMEOUT cycles elapsed -> ERROR.
//  RUN: adc_run=1, rate_req_ready=1.
//  ERROR: cal_error=1, adc_run=0, ADC_RSTN=1, rate_req_ready=1.
//  Request handling (RUN or ERROR only):
//   valid & rate_req!=11 -> latch pending rate, clear cal_error/adc_run next cycle, -> RST.
//   valid & rate_req==11 -> req_reject pulses next cycle; state unchanged.
//   A legal request equal to rate_cur still re-runs RST and calibration.
//  rate_req_ready=0 in PWRUP/RST/CAL_RISE/CAL_FALL; requests there are ignored, not queued.
//  adc_run deasserts on the cycle ADC_RSTN falls, never later.
//  rate_cur updates with ADC_DFS.
//  Counters saturate and never wrap; 25-bit PWRUP counter, 24-bit shared counter elsewhere.
//  Async reset mid-sequence: immediate return to reset values; full PWRUP delay repeats.
//  cal_s toggling inside CAL_FALL: first low sample ends calibration; no glitch filtering.
// TESTING (bench overrides VREF_DELAY=16, CAL_RISE_WIN=8, CAL_TIMEOUT=64)
//  Power-up, CAL model: high 3 cycles after RSTN rise, for 20 cycles ->
//   ADC_RSTN high 16 cycles, low exactly 4 cycles, adc_run=1 after CAL falls + sync.
//  In RUN, request 10 -> ready seen, ADC_RSTN low 4 cycles, ADC_DFS=10 while low,
//   rate_cur=10, adc_run=0 until recal done.
//  Request 11 in RUN -> req_reject single pulse; ADC_DFS, adc_run unchanged.
//  CAL never rises -> ERROR 8 cycles after RSTN release, cal_error=1.
//   Then request 01 -> recovers to RUN with DFS=01.
//  CAL stuck high -> ERROR after 64 cycles in CAL_FALL.
//   Requests during CAL_FALL -> ready=0, ignored.
//  Assert reset during CAL_FALL -> ADC_RSTN=0, DFS=00, adc_run=0 immediately.
//   After release, 16-cycle PWRUP repeats.

Source files
------------

// File: rtl/ak5394a_rate_sequencer_if.sv
// Rate-request channel between host control logic and the AK5394A sequencer.
// Latency: ready/reject are registered in the sequencer; a request fires on valid&ready.
// Backpressure: ready is low while a reset/calibration pass runs; requests then are dropped.
interface ak5394a_rate_sequencer_if;
  logic [1:0] rate_req;
  logic       rate_req_valid;
  logic       rate_req_ready;
  logic       req_reject;

  modport master (
    output rate_req,
    output rate_req_valid,
    input  rate_req_ready,
    input  req_reject
  );

  modport slave (
    input  rate_req,
    input  rate_req_valid,
    output rate_req_ready,
    output req_reject
  );
endinterface

// File: rtl/ak5394a_rate_sequencer.sv
// AK5394A power-up, reset, rate-select and calibration sequencer on ADC_MCLK.
// Latency: all outputs registered; an accepted request drops ADC_RSTN on the next edge.
// Backpressure: rate_req_ready only in RUN/ERROR; other-state requests are ignored, not queued.
module ak5394a_rate_sequencer #(
  parameter logic [24:0] VREF_DELAY   = 25'hCE5000,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned CAL_RISE_WIN = 1024,
  parameter logic [23:0] CAL_TIMEOUT  = 24'h100000
) (
  input  logic                      ADC_MCLK,
  input  logic                      reset,
  ak5394a_rate_sequencer_if.slave   req_if,
  input  logic                      ADC_CAL,
  output logic                      ADC_RSTN,
  output logic [1:0]                ADC_DFS,
  output logic                      adc_run,
  output logic                      cal_error,
  output logic [1:0]                rate_cur
);

  localparam logic [23:0] RST_LAST      = 24'(RST_CYCLES - 1);
  localparam logic [23:0] CAL_RISE_LAST = 24'(CAL_RISE_WIN - 1);
  localparam logic [23:0] CAL_TO_LAST   = CAL_TIMEOUT - 24'd1;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_RST,
    S_CAL_RISE,
    S_CAL_FALL,
    S_RUN,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] pwr_cnt_q, pwr_cnt_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  cal_sync_q, cal_sync_d;
  logic [1:0]  pend_rate_q, pend_rate_d;
  logic        adc_rstn_q, adc_rstn_d;
  logic [1:0]  adc_dfs_q, adc_dfs_d;
  logic        adc_run_q, adc_run_d;
  logic        cal_error_q, cal_error_d;
  logic        rdy_q, rdy_d;
  logic        reject_q, reject_d;

  logic        cal_s;
  logic        req_fire;
  logic        req_legal;
  logic [23:0] cnt_inc;

  // Next-state, counters and registered-output values
  always_comb begin
    cal_s       = cal_sync_q[1];
    req_fire    = req_if.rate_req_valid & rdy_q;
    req_legal   = (req_if.rate_req != 2'b11);
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;

    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    cnt_d       = cnt_q;
    cal_sync_d  = {cal_sync_q[0], ADC_CAL};
    pend_rate_d = pend_rate_q;
    adc_dfs_d   = adc_dfs_q;
    reject_d    = 1'b0;

    case (state_q)
      // The cycle right after reset still shows RSTN low, so the counter equals the
      // number of RSTN-high cycles; leaving at VREF_DELAY gives the full settle time.
      S_PWRUP: begin
        if (pwr_cnt_q == VREF_DELAY) begin
          state_d = S_RST;
          cnt_d   = '0;
        end else if (pwr_cnt_q != '1) begin
          pwr_cnt_d = pwr_cnt_q + 25'd1;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_CAL_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_CAL_RISE: begin
        if (cal_s) begin
          state_d = S_CAL_FALL;
          cnt_d   = '0;
        end else if (cnt_q == CAL_RISE_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // No filtering: the first low synchronized sample ends calibration.
      S_CAL_FALL: begin
        if (!cal_s) begin
          state_d = S_RUN;
        end else if (cnt_q == CAL_TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // Any legal rate, even the current one, reruns reset and calibration.
      S_RUN, S_ERROR: begin
        if (req_fire) begin
          if (req_legal) begin
            pend_rate_d = req_if.rate_req;
            state_d     = S_RST;
            cnt_d       = '0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_PWRUP;
      end
    endcase

    // DFS loads only on the edge that pulls RSTN low, so it never moves while RSTN is high.
    if (state_d == S_RST && state_q != S_RST) begin
      adc_dfs_d = pend_rate_d;
    end

    // Outputs follow the next state so adc_run drops on the same edge RSTN falls.
    adc_rstn_d  = (state_d != S_RST);
    adc_run_d   = (state_d == S_RUN);
    cal_error_d = (state_d == S_ERROR);
    rdy_d       = (state_d == S_RUN) || (state_d == S_ERROR);
  end

  // State, counters, CAL synchronizer and registered outputs
  always_ff @(posedge ADC_MCLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_PWRUP;
      pwr_cnt_q   <= '0;
      cnt_q       <= '0;
      cal_sync_q  <= '0;
      pend_rate_q <= 2'b00;
      adc_rstn_q  <= 1'b0;
      adc_dfs_q   <= 2'b00;
      adc_run_q   <= 1'b0;
      cal_error_q <= 1'b0;
      rdy_q       <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      cnt_q       <= cnt_d;
      cal_sync_q  <= cal_sync_d;
      pend_rate_q <= pend_rate_d;
      adc_rstn_q  <= adc_rstn_d;
      adc_dfs_q   <= adc_dfs_d;
      adc_run_q   <= adc_run_d;
      cal_error_q <= cal_error_d;
      rdy_q       <= rdy_d;
      reject_q    <= reject_d;
    end
  end

  assign ADC_RSTN              = adc_rstn_q;
  assign ADC_DFS               = adc_dfs_q;
  assign rate_cur              = adc_dfs_q;
  assign adc_run               = adc_run_q;
  assign cal_error             = cal_error_q;
  assign req_if.rate_req_ready = rdy_q;
  assign req_if.req_reject     = reject_q;

endmodule

// File: tb/tb_ak5394a_rate_sequencer.sv
// Directed bench for the AK5394A rate sequencer with a small CAL-pin model.
// Latency: expected cycle counts are hand-derived from the sequencing rules.
// Backpressure: requests outside RUN/ERROR are driven and must be ignored.
module tb_ak5394a_rate_sequencer;
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       adc_cal;
  logic       adc_rstn;
  logic [1:0] adc_dfs;
  logic       adc_run;
  logic       cal_error;
  logic [1:0] rate_cur;

  int n_cmp    = 0;
  int n_fail   = 0;
  int cal_mode = 0;  // 0: normal pulse, 1: never rises, 2: stuck high

  ak5394a_rate_sequencer_if rif();

  ak5394a_rate_sequencer #(
    .VREF_DELAY  (25'd16),
    .RST_CYCLES  (4),
    .CAL_RISE_WIN(8),
    .CAL_TIMEOUT (24'd64)
  ) dut (
    .ADC_MCLK (clk),
    .reset    (reset),
    .req_if   (rif),
    .ADC_CAL  (adc_cal),
    .ADC_RSTN (adc_rstn),
    .ADC_DFS  (adc_dfs),
    .adc_run  (adc_run),
    .cal_error(cal_error),
    .rate_cur (rate_cur)
  );

  always #5 clk = ~clk;

  // ADC CAL pin model: high 3 cycles after RSTN rises, for 20 cycles (mode 0)
  initial begin : cal_model
    int   since;
    logic prev;
    since   = -1;
    prev    = 1'b0;
    adc_cal = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_rstn !== 1'b1) since = -1;
      else if (!prev) since = 0;
      else if (since >= 0 && since < 100000) since++;
      prev = (adc_rstn === 1'b1);
      case (cal_mode)
        1:       adc_cal = 1'b0;
        2:       adc_cal = (since >= 3);
        default: adc_cal = (since >= 3 && since < 23);
      endcase
    end
  end

  // Count negedges while RSTN stays at lvl (bounded)
  task automatic count_level(input logic lvl, input int bound, output int n);
    n = 0;
    while (adc_rstn === lvl && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send_req(input logic [1:0] r);
    rif.rate_req       = r;
    rif.rate_req_valid = 1'b1;
    @(negedge clk);
    rif.rate_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (adc_rstn !== 1'b0) begin n_fail++; $display("FAIL reset_rstn: got %b want 0", adc_rstn); end
    n_cmp++; if (adc_dfs !== 2'b00) begin n_fail++; $display("FAIL reset_dfs: got %b want 00", adc_dfs); end
    n_cmp++; if (rate_cur !== 2'b00) begin n_fail++; $display("FAIL reset_rate_cur: got %b want 00", rate_cur); end
    n_cmp++; if (adc_run !== 1'b0) begin n_fail++; $display("FAIL reset_adc_run: got %b want 0", adc_run); end
    n_cmp++; if (cal_error !== 1'b0) begin n_fail++; $display("FAIL reset_cal_error: got %b want 0", cal_error); end
    n_cmp++; if (rif.rate_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", rif.rate_req_ready); end
    n_cmp++; if (rif.req_reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b want 0", rif.req_reject); end
  endtask

  task automatic test_powerup();
    int n;
    reset = 1'b0;
    @(negedge clk);
    count_level(1'b1, 200, n);
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL pu_rstn_high: got %0d want 16", n); end
    n_cmp++; if (adc_dfs !== 2'b00) begin n_fail++; $display("FAIL pu_dfs: got %b want 00", adc_dfs); end
    count_level(1'b0, 200, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL pu_rstn_low: got %0d want 4", n); end
    n = 0;
    while (adc_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 26) begin n_fail++; $display("FAIL pu_run_latency: got %0d want 26", n); end
    n_cmp++; if (rif.rate_req_ready !== 1'b1) begin n_fail++; $display("FAIL pu_ready: got %b want 1", rif.rate_req_ready); end
    n_cmp++; if (cal_error !== 1'b0) begin n_fail++; $display("FAIL pu_cal_error: got %b want 0", cal_error); end
  endtask

  task automatic test_rate_change();
    int n;
    n_cmp++; if (rif.rate_req_ready !== 1'b1) begin n_fail++; $display("FAIL rc_ready: got %b want 1", rif.rate_req_ready); end
    send_req(2'b10);
    n_cmp++; if (adc_rstn !== 1'b0) begin n_fail++; $display("FAIL rc_rstn: got %b want 0", adc_rstn); end
    n_cmp++; if (adc_run !== 1'b0) begin n_fail++; $display("FAIL rc_run_drop: got %b want 0", adc_run); end
    n_cmp++; if (adc_dfs !== 2'b10) begin n_fail++; $display("FAIL rc_dfs: got %b want 10", adc_dfs); end
    n_cmp++; if (rate_cur !== 2'b10) begin n_fail++; $display("FAIL rc_rate_cur: got %b want 10", rate_cur); end
    count_level(1'b0, 200, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL rc_rstn_low: got %0d want 4", n); end
    n = 0;
    while (adc_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 26) begin n_fail++; $display("FAIL rc_run_latency: got %0d want 26", n); end
    n_cmp++; if (adc_dfs !== 2'b10) begin n_fail++; $display("FAIL rc_dfs_run: got %b want 10", adc_dfs); end
  endtask

  task automatic test_reject();
    send_req(2'b11);
    n_cmp++; if (rif.req_reject !== 1'b1) begin n_fail++; $display("FAIL rj_pulse: got %b want 1", rif.req_reject); end
    n_cmp++; if (adc_dfs !== 2'b10) begin n_fail++; $display("FAIL rj_dfs: got %b want 10", adc_dfs); end
    n_cmp++; if (adc_run !== 1'b1) begin n_fail++; $display("FAIL rj_run: got %b want 1", adc_run); end
    n_cmp++; if (adc_rstn !== 1'b1) begin n_fail++; $display("FAIL rj_rstn: got %b want 1", adc_rstn); end
    @(negedge clk);
    n_cmp++; if (rif.req_reject !== 1'b0) begin n_fail++; $display("FAIL rj_single: got %b want 0", rif.req_reject); end
    n_cmp++; if (adc_run !== 1'b1) begin n_fail++; $display("FAIL rj_run_after: got %b want 1", adc_run); end
  endtask

  task automatic test_cal_never();
    int n;
    cal_mode = 1;
    send_req(2'b00);
    n_cmp++; if (adc_dfs !== 2'b00) begin n_fail++; $display("FAIL cn_dfs: got %b want 00", adc_dfs); end
    count_level(1'b0, 200, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL cn_rstn_low: got %0d want 4", n); end
    n = 0;
    while (cal_error !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 8) begin n_fail++; $display("FAIL cn_err_latency: got %0d want 8", n); end
    n_cmp++; if (adc_run !== 1'b0) begin n_fail++; $display("FAIL cn_run: got %b want 0", adc_run); end
    n_cmp++; if (adc_rstn !== 1'b1) begin n_fail++; $display("FAIL cn_rstn_err: got %b want 1", adc_rstn); end
    n_cmp++; if (rif.rate_req_ready !== 1'b1) begin n_fail++; $display("FAIL cn_ready: got %b want 1", rif.rate_req_ready); end
    send_req(2'b01);
    cal_mode = 0;
    n_cmp++; if (cal_error !== 1'b0) begin n_fail++; $display("FAIL cn_err_clear: got %b want 0", cal_error); end
    n_cmp++; if (adc_dfs !== 2'b01) begin n_fail++; $display("FAIL cn_dfs_rec: got %b want 01", adc_dfs); end
    count_level(1'b0, 200, n);
    n = 0;
    while (adc_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 26) begin n_fail++; $display("FAIL cn_recover: got %0d want 26", n); end
    n_cmp++; if (rate_cur !== 2'b01) begin n_fail++; $display("FAIL cn_rate_cur: got %b want 01", rate_cur); end
  endtask

  task automatic test_cal_stuck();
    int n;
    cal_mode = 2;
    send_req(2'b10);
    count_level(1'b0, 200, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL cs_rstn_low: got %0d want 4", n); end
    n = 0;
    while (cal_error !== 1'b1 && n < 300) begin
      if (n == 20) begin
        rif.rate_req       = 2'b01;
        rif.rate_req_valid = 1'b1;
        n_cmp++; if (rif.rate_req_ready !== 1'b0) begin n_fail++; $display("FAIL cs_ready: got %b want 0", rif.rate_req_ready); end
      end
      if (n == 24) rif.rate_req_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    rif.rate_req_valid = 1'b0;
    n_cmp++; if (n !== 70) begin n_fail++; $display("FAIL cs_err_latency: got %0d want 70", n); end
    n_cmp++; if (adc_dfs !== 2'b10) begin n_fail++; $display("FAIL cs_req_ignored: got %b want 10", adc_dfs); end
    n_cmp++; if (adc_run !== 1'b0) begin n_fail++; $display("FAIL cs_run: got %b want 0", adc_run); end
  endtask

  task automatic test_async_reset();
    int n;
    send_req(2'b10);
    count_level(1'b0, 200, n);
    repeat (10) @(negedge clk);
    n_cmp++; if (adc_rstn !== 1'b1) begin n_fail++; $display("FAIL ar_pre_rstn: got %b want 1", adc_rstn); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (adc_rstn !== 1'b0) begin n_fail++; $display("FAIL ar_rstn: got %b want 0", adc_rstn); end
    n_cmp++; if (adc_dfs !== 2'b00) begin n_fail++; $display("FAIL ar_dfs: got %b want 00", adc_dfs); end
    n_cmp++; if (rate_cur !== 2'b00) begin n_fail++; $display("FAIL ar_rate_cur: got %b want 00", rate_cur); end
    n_cmp++; if (adc_run !== 1'b0) begin n_fail++; $display("FAIL ar_run: got %b want 0", adc_run); end
    cal_mode = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    count_level(1'b1, 200, n);
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL ar_pwrup: got %0d want 16", n); end
    count_level(1'b0, 200, n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL ar_rstn_low: got %0d want 4", n); end
    n = 0;
    while (adc_run !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++; if (n !== 26) begin n_fail++; $display("FAIL ar_run_latency: got %0d want 26", n); end
    n_cmp++; if (adc_dfs !== 2'b00) begin n_fail++; $display("FAIL ar_dfs_run: got %b want 00", adc_dfs); end
  endtask

  initial begin
    rif.rate_req       = 2'b00;
    rif.rate_req_valid = 1'b0;
    test_reset();
    test_powerup();
    test_rate_change();
    test_reject();
    test_cal_never();
    test_cal_stuck();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
